i2s_tx_24: RTL and testbench

- Serializes signed 24-bit stereo samples (left_to_board/right_to_board from the 16-to-24 converter) onto a standard Philips I2S link to the board audio codec.
- Generates BCLK/LRCLK as master, with a one-deep holding register and valid/ready handshake on the sample side.
- Sits between the converter output and the codec pins, in the YM2151 audio path.

---
 rtl/i2s_tx_pkg.sv | 11 +
 rtl/i2s_bclk_gen.sv | 27 ++
 rtl/i2s_tx_24.sv | 87 ++++++++
 tb/tb_i2s_tx_24.sv | 129 ++++++++++++
 4 files changed

// File: rtl/i2s_tx_pkg.sv
// i2s_tx_pkg: shared constants and types for the 24-bit I2S transmitter
package i2s_tx_pkg;
  localparam int DATA_W_DEF = 24;
  localparam int SLOT_W_DEF = 32;
  localparam int FRAME_BITS = 64;
  typedef logic [$clog2(FRAME_BITS)-1:0] bit_cnt_t;
  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] left;
    logic signed [DATA_W_DEF-1:0] right;
  } pair_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides clk into BCLK and flags the clk cycle on which BCLK falls
//   clk, rst_n : clock, async active-low reset
//   o_bclk     : registered bit clock, period 2*CLK_DIV clk
//   o_fall     : high in the cycle whose edge takes o_bclk from 1 to 0
module i2s_bclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_bclk,
  output logic o_fall
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] r_div;
  logic r_bclk, w_wrap;
  assign w_wrap = r_div == DW'(CLK_DIV - 1);
  assign o_fall = w_wrap && r_bclk;
  assign o_bclk = r_bclk;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_div  <= w_wrap ? '0 : r_div + 1'b1;
      r_bclk <= r_bclk ^ w_wrap;
    end
endmodule

// File: rtl/i2s_tx_24.sv
// i2s_tx_24: Philips I2S master transmitter for signed stereo samples, one-deep holding register
//   clk, rst_n          : clock, async active-low reset
//   sample_valid/ready  : handshake; a pair is taken when both are high
//   left, right         : signed sample pair
//   underrun            : one-clk pulse when a frame starts without a fresh pair
//   bclk, lrclk, sdata  : codec pins, all registered
//   Build option I2S_TX_UNDERRUN_MUTE_EN: transmit silence instead of repeating on underrun
module i2s_tx_24 import i2s_tx_pkg::*; #(
  parameter int CLK_DIV = 8,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SLOT_W  = SLOT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  output logic              sample_ready,
  output logic              underrun,
  output logic              bclk,
  output logic              lrclk,
  output logic              sdata
);
  localparam int CW = $clog2(2 * SLOT_W);
  localparam logic [CW-1:0] LAST = CW'(2 * SLOT_W - 1);
  logic w_fall, w_load, w_accept, w_hi, w_bit;
  logic [CW-1:0] r_bit_cnt, w_next, w_p, w_idx;
  logic [DATA_W-1:0] r_hold_l, r_hold_r, r_sh_l, r_sh_r, w_word;
  logic r_hold_full, r_lrclk, r_sdata, r_underrun;
  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_bclk (bclk),
    .o_fall (w_fall)
  );
  // Slot position p maps to shadow bit DATA_W-p; p=0 is the I2S one-bit delay slot.
  always_comb begin
    w_load   = w_fall && (r_bit_cnt == LAST);
    w_accept = sample_valid && !r_hold_full;
    w_next   = w_load ? '0 : r_bit_cnt + 1'b1;
    w_hi     = w_next >= CW'(SLOT_W);
    w_p      = w_hi ? w_next - CW'(SLOT_W) : w_next;
    w_idx    = CW'(DATA_W) - w_p;
    w_word   = w_hi ? r_sh_r : r_sh_l;
    w_bit    = (w_p != '0) && (w_p <= CW'(DATA_W)) && |(w_word & (DATA_W'(1) << w_idx));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_bit_cnt   <= LAST;
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
      r_sh_l      <= '0;
      r_sh_r      <= '0;
      r_lrclk     <= 1'b0;
      r_sdata     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_underrun <= w_load && !r_hold_full;
      if (w_fall) begin
        r_bit_cnt <= w_next;
        r_lrclk   <= w_hi;
        r_sdata   <= w_bit;
      end
      if (w_load && r_hold_full) begin
        r_sh_l <= r_hold_l;
        r_sh_r <= r_hold_r;
      end
`ifdef I2S_TX_UNDERRUN_MUTE_EN
      else if (w_load) begin
        r_sh_l <= '0;
        r_sh_r <= '0;
      end
`endif
      // No bypass: a pair accepted on a load edge waits in holding for the next frame.
      if (w_load && r_hold_full) r_hold_full <= 1'b0;
      else if (w_accept) begin
        r_hold_full <= 1'b1;
        r_hold_l    <= left;
        r_hold_r    <= right;
      end
    end
  assign sample_ready = !r_hold_full;
  assign underrun     = r_underrun;
  assign lrclk        = r_lrclk;
  assign sdata        = r_sdata;
endmodule

// File: tb/tb_i2s_tx_24.sv
// tb_i2s_tx_24: randomized self-checking bench against a frame-level I2S reference model
module tb_i2s_tx_24;
  localparam int CD = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sample_valid = 1'b0;
  logic [23:0] left = '0, right = '0;
  logic sample_ready, underrun, bclk, lrclk, sdata;
  int checks = 0, failures = 0;
  int cyc, m_n, k;
  logic m_full, m_acc, m_u, m_lr, m_sd;
  logic [23:0] pl, pr, cl, cr;
  i2s_tx_24 #(.CLK_DIV(CD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .left         (left),
    .right        (right),
    .sample_ready (sample_ready),
    .underrun     (underrun),
    .bclk         (bclk),
    .lrclk        (lrclk),
    .sdata        (sdata)
  );
  always #5 clk = ~clk;
  function automatic logic frame_bit(input logic [23:0] l, input logic [23:0] r, input int n);
    logic [63:0] f;
    f = {1'b0, l, 7'b0, 1'b0, r, 7'b0};
    return f[63-n];
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask
  task automatic model_reset();
    cyc = 0; m_n = 63; m_full = 0; m_acc = 0; m_u = 0; m_lr = 0; m_sd = 0;
    pl = '0; pr = '0; cl = '0; cr = '0;
  endtask
  task automatic check_reset_outs(input string tag);
    chk({tag, "_bclk"}, int'(bclk), 0);
    chk({tag, "_lrclk"}, int'(lrclk), 0);
    chk({tag, "_sdata"}, int'(sdata), 0);
    chk({tag, "_underrun"}, int'(underrun), 0);
    chk({tag, "_ready"}, int'(sample_ready), 1);
  endtask
  task automatic do_reset(input int n);
    sample_valid = 0;
    rst_n = 0;
    repeat (n) begin
      @(posedge clk); #1;
      check_reset_outs("rst");
    end
    rst_n = 1;
    model_reset();
  endtask
  task automatic tick();
    logic fall, ld;
    int n;
    @(posedge clk); #1;
    cyc++;
    fall = (cyc % (2 * CD)) == 0;
    n = fall ? (cyc / (2 * CD) - 1) % 64 : 0;
    ld = fall && n == 0;
    m_acc = sample_valid && !m_full;
    m_u = ld && !m_full;
    if (ld && m_full) begin
      cl = pl; cr = pr; m_full = 0;
    end else if (ld) begin
`ifdef I2S_TX_UNDERRUN_MUTE_EN
      cl = '0; cr = '0;
`endif
    end
    if (m_acc) begin
      pl = left; pr = right; m_full = 1;
    end
    if (fall) begin
      m_n = n; m_lr = n >= 32; m_sd = frame_bit(cl, cr, n);
    end
    chk("bclk", int'(bclk), (cyc / CD) % 2);
    chk("lrclk", int'(lrclk), int'(m_lr));
    chk("sdata", int'(sdata), int'(m_sd));
    chk("underrun", int'(underrun), int'(m_u));
    chk("ready", int'(sample_ready), int'(!m_full));
  endtask
  task automatic drive_random(input int pct);
    if (!sample_valid || m_acc) begin
      sample_valid = $urandom_range(0, 99) < pct;
      left = 24'($urandom);
      right = 24'($urandom);
    end
  endtask
  initial begin
    #2 rst_n = 0;
    do_reset(10);
    repeat (520) tick();
    do_reset(4);
    left = 24'h800001; right = 24'h7FFFFE; sample_valid = 1; k = 0;
    repeat (800) begin
      tick();
      if (m_acc) begin
        k++;
        if (k == 1) begin
          left = 24'h123456; right = 24'hABCDEF;
        end else sample_valid = 0;
      end
    end
    for (int i = 0; i < 6000; i++) begin
      tick();
      drive_random(((i / 700) % 2) ? 3 : 70);
    end
    for (int i = 0; i < 400 && m_n != 40; i++) begin
      tick();
      drive_random(50);
    end
    chk("at_bit40", m_n, 40);
    #2 rst_n = 0;
    #1 check_reset_outs("midrst");
    do_reset(3);
    for (int i = 0; i < 1200; i++) begin
      tick();
      drive_random(40);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
